// File: rtl/carry_chain_acc_if.sv
// rtl/carry_chain_acc_if.sv - operand/control/result bundle between the accumulator and its driver
interface carry_chain_acc_if #(
   parameter int WIDTH = 8
);
   logic             QEN;
   logic             IN_VLD;
   logic             IN_RDY;
   logic [1:0]       OP;
   logic [WIDTH-1:0] LI;
   logic             CI;
   logic [WIDTH-1:0] AQZ;
   logic             CO;
   logic             OVF;
   logic             OUT_VLD;

   modport master (
      output QEN, IN_VLD, OP, LI, CI,
      input  IN_RDY, AQZ, CO, OVF, OUT_VLD
   );

   modport slave (
      input  QEN, IN_VLD, OP, LI, CI,
      output IN_RDY, AQZ, CO, OVF, OUT_VLD
   );
endinterface

// File: rtl/carry_chain_acc.sv
// rtl/carry_chain_acc.sv - two-cycle split-carry accumulator (low half at accept, high half next edge)
// Optional CARRY_CHAIN_ACC_SAT_EN: clamp add/sub results to signed max/min on overflow.
module carry_chain_acc #(
   parameter int WIDTH = 8
) (
   input  logic             QCK,
   input  logic             QRT,
   carry_chain_acc_if.slave bus
);
   localparam int LO = WIDTH / 2;
   localparam int HW = WIDTH - LO;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic {IDLE, HI} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             in_rdy;
   logic             accept;

   logic [1:0]       op_q;
   logic [HW-1:0]    li_hi_q;
   logic [LO-1:0]    lo_sum_q;
   logic             lo_carry_q;

   logic [WIDTH-1:0] aqz_q;
   logic             co_q;
   logic             ovf_q;
   logic             out_vld_q;

   logic [LO-1:0]    lo_opnd;
   logic [LO:0]      lo_sum;
   logic [LO-1:0]    lo_next;
   logic [HW-1:0]    hi_opnd;
   logic [HW:0]      hi_sum;
   logic [WIDTH-1:0] arith_res;
   logic [WIDTH-1:0] final_res;
   logic             arith_co;
   logic             ovf_now;

   // FSM state register
   always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
         state <= IDLE;
      end else if (bus.QEN) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_rdy = 1'b1;
            if (bus.IN_VLD && bus.QEN) begin
               accept    = 1'b1;
               state_nxt = HI;
            end
         end
         HI: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Low half is summed at accept; AQZ is stable until the HI edge so this is safe.
   always_comb begin
      lo_opnd = (bus.OP == OP_SUB) ? ~bus.LI[LO-1:0] : bus.LI[LO-1:0];
      lo_sum  = {1'b0, aqz_q[LO-1:0]} + {1'b0, lo_opnd} + {{LO{1'b0}}, bus.CI};
      case (bus.OP)
         OP_LOAD: lo_next = bus.LI[LO-1:0];
         OP_HOLD: lo_next = aqz_q[LO-1:0];
         default: lo_next = lo_sum[LO-1:0];
      endcase
   end

   always_comb begin
      hi_opnd   = (op_q == OP_SUB) ? ~li_hi_q : li_hi_q;
      hi_sum    = {1'b0, aqz_q[WIDTH-1:LO]} + {1'b0, hi_opnd} + {{HW{1'b0}}, lo_carry_q};
      arith_res = {hi_sum[HW-1:0], lo_sum_q};
      arith_co  = hi_sum[HW];
      ovf_now   = (aqz_q[WIDTH-1] == hi_opnd[HW-1]) &&
                  (arith_res[WIDTH-1] != aqz_q[WIDTH-1]);
`ifdef CARRY_CHAIN_ACC_SAT_EN
      // Both operands share a sign on overflow; a positive sign means positive overflow.
      if (ovf_now) begin
         final_res = aqz_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         final_res = arith_res;
      end
`else
      final_res = arith_res;
`endif
   end

   always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
         op_q       <= OP_HOLD;
         li_hi_q    <= '0;
         lo_sum_q   <= '0;
         lo_carry_q <= 1'b0;
         aqz_q      <= '0;
         co_q       <= 1'b0;
         ovf_q      <= 1'b0;
         out_vld_q  <= 1'b0;
      end else if (bus.QEN) begin
         out_vld_q <= 1'b0;
         if (accept) begin
            op_q       <= bus.OP;
            li_hi_q    <= bus.LI[WIDTH-1:LO];
            lo_sum_q   <= lo_next;
            lo_carry_q <= lo_sum[LO];
         end
         if (state == HI) begin
            out_vld_q <= 1'b1;
            case (op_q)
               OP_ADD, OP_SUB: begin
                  aqz_q <= final_res;
                  co_q  <= arith_co;
                  if (ovf_now) begin
                     ovf_q <= 1'b1;
                  end
               end
               OP_LOAD: begin
                  aqz_q <= {li_hi_q, lo_sum_q};
                  co_q  <= 1'b0;
                  ovf_q <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.IN_RDY  = in_rdy;
   assign bus.AQZ     = aqz_q;
   assign bus.CO      = co_q;
   assign bus.OVF     = ovf_q;
   assign bus.OUT_VLD = out_vld_q;
endmodule

// File: doc/carry_chain_acc.md
# carry_chain_acc

Registered accumulator that sits directly upstream of the logic-cell adder slices and drives their operand, carry-in and flip-flop control inputs. It models a WIDTH-bit carry chain split into two halves with a registered carry break between them, so one operation takes two cycles. The accumulated value, carry-out and a sticky overflow flag are exposed for the downstream cells to consume.

## Interface
Parameters:
- WIDTH, 8, accumulator width; even, ≥2; low half LO = WIDTH/2 bits, high half = WIDTH/2 bits.

Ports:
- QCK  input  1  clock; all state updates on rising edge.
- QRT  input  1  reset, asynchronous, active-high.
- QEN  input  1  clock enable; 0 freezes all state, including OUT_VLD.
- IN_VLD  input  1  operation request.
- IN_RDY  output  1  accept-ready; combinational, equals (state == IDLE).
- OP  input  2  00 hold, 01 add, 10 sub, 11 load.
- LI  input  WIDTH  operand.
- CI  input  1  carry-in into bit 0.
- AQZ  output  WIDTH  registered accumulator.
- CO  output  1  registered carry-out of the MSB.
- OVF  output  1  sticky signed-overflow flag.
- OUT_VLD  output  1  result-valid pulse.

## Operation
- States: IDLE, HI.
- Accept: edge where state = IDLE, IN_VLD = 1, QEN = 1. Latch OP, the high half of LI, and CI. Compute the low-half sum, then register it with the low-half carry. Go to HI.
- HI (QEN = 1): compute the high half using the registered carry. Write all of AQZ atomically. Update CO and OVF. Set OUT_VLD. Go to IDLE.
- Arithmetic:
  - add: AQZ + LI + CI.
  - sub: AQZ + ~LI + CI. CI = 1 gives a true subtract; CO = 1 means no borrow.
  - load: AQZ ← LI, CO ← 0, OVF ← 0.
  - hold: AQZ and CO unchanged, OVF unchanged; OUT_VLD still pulses.
- Overflow for add/sub: signed overflow when the operand MSBs are equal (LI MSB inverted for sub) and the result MSB differs. OVF is set when overflow occurs and clears only on QRT or load.
- The low half of AQZ is never visible partially updated. AQZ changes only on the HI edge.
- Operands are sampled at the accept edge only. Changes to LI, OP or CI during HI are ignored. IN_VLD during HI is ignored (IN_RDY = 0).
- QEN = 0: state, pipeline registers, AQZ, CO, OVF and OUT_VLD all hold. No accept occurs.
- QRT at any time, including mid-operation: state → IDLE, pipeline discarded, no OUT_VLD for the aborted operation.

## Timing
- Reset values: AQZ = 0, CO = 0, OVF = 0, OUT_VLD = 0, state = IDLE, IN_RDY = 1.
- Accept at edge k. HI completes at edge k+1 (given QEN = 1); AQZ, CO, OVF and OUT_VLD become valid after edge k+1.
- OUT_VLD is high for exactly one QEN-enabled cycle and clears at the next enabled edge.
- IN_RDY rises after edge k+1. The earliest next accept is edge k+2, so throughput is 1 operation per 2 cycles.
- QEN low for n cycles while in HI delays completion by exactly n cycles.

## Configuration
- CARRY_CHAIN_ACC_SAT_EN defined: on signed overflow in add/sub, AQZ clamps to the signed max (0x7F for WIDTH = 8) for positive overflow or the signed min (0x80) for negative overflow. CO keeps the raw carry and OVF is still set.
- Undefined: AQZ wraps modulo 2^WIDTH.

## Test plan
- Reset: pulse QRT asynchronously mid-cycle. Expect AQZ = 0x00, CO = 0, OVF = 0, OUT_VLD = 0, IN_RDY = 1 immediately.
- Cross-half carry: load 0x0F, then add 0x01 with CI = 0. Expect AQZ = 0x10, CO = 0, OUT_VLD pulsing one cycle after HI, IN_RDY low for one cycle.
- Wrap and carry: load 0x01, then add 0xFF with CI = 0. Expect AQZ = 0x00, CO = 1, OVF = 0.
- Overflow: load 0x7F, then add 0x01.
  - Macro off: AQZ = 0x80, OVF = 1.
  - Macro on: AQZ = 0x7F, OVF = 1.
  - A following load 0x00 clears OVF.
- Subtract: load 0x05, then sub 0x03 with CI = 1. Expect AQZ = 0x02, CO = 1. Then sub 0x03 with CI = 1 again. Expect AQZ = 0xFF, CO = 0.
- Stall and abort:
  - QEN low for 3 cycles during HI: AQZ and OUT_VLD are frozen, and the result appears 1 cycle after QEN returns.
  - QRT asserted during HI: AQZ = 0 and no OUT_VLD pulse follows.
